// File: rtl/pwm_audio_dac_if.sv
// Sample/control bundle between the demodulator side and the 1-bit audio DAC stage.
// The master drives samples and controls; the slave (the DAC) returns the output pin and status pulses.
interface pwm_audio_dac_if #(
  parameter int IN_W = 16
);
  logic [IN_W-1:0] sample_in;
  logic            sample_tick;
  logic [2:0]      gain;
  logic            mode;
  logic            enable;
  logic            pwm_out;
  logic            period_tick;
  logic            overrun;

  modport master (
    output sample_in, sample_tick, gain, mode, enable,
    input  pwm_out, period_tick, overrun
  );

  modport slave (
    input  sample_in, sample_tick, gain, mode, enable,
    output pwm_out, period_tick, overrun
  );
endinterface

// File: rtl/pwm_audio_dac.sv
// Audio output stage: gain with saturation, offset-binary conversion, double-buffered duty,
// and a 1-bit output as fixed-period PWM or first-order sigma-delta.
module pwm_audio_dac #(
  parameter int IN_W      = 16,
  parameter int PWM_W     = 10,
  parameter bit SIGNED_IN = 1'b1
) (
  input logic              clk,
  input logic              RSTb,
  pwm_audio_dac_if.slave   bus
);

  typedef enum logic {
    MODE_PWM = 1'b0,
    MODE_SD  = 1'b1
  } mode_e;

  localparam int XW = IN_W + 8;
  localparam logic signed [XW-1:0] SMAX = {{9{1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = {{9{1'b1}}, {(IN_W-1){1'b0}}};

  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] acc;
  logic [PWM_W-1:0] duty_act;
  logic [IN_W-1:0]  pend;
  logic             pend_full;
  mode_e            mode_act;
  logic             pwm_out_q;
  logic             period_tick_q;
  logic             overrun_q;

  logic                   boundary;
  logic signed [XW-1:0]   ext;
  logic signed [XW-1:0]   shifted;
  logic [PWM_W-1:0]       duty_new;
  logic [PWM_W:0]         sd_sum;

  assign boundary = bus.enable && (cnt == '1);
  assign sd_sum   = {1'b0, acc} + {1'b0, duty_act};

  // Saturation is decided on the widened value; the duty is then the top PWM_W bits
  // of the offset-binary result (MSB flip for signed input).
  always_comb begin
    ext      = '0;
    shifted  = '0;
    duty_new = '0;
    if (SIGNED_IN) begin
      ext     = {{8{pend[IN_W-1]}}, pend};
      shifted = ext <<< bus.gain;
      if (shifted > SMAX)
        duty_new = '1;
      else if (shifted < SMIN)
        duty_new = '0;
      else
        duty_new = {~shifted[IN_W-1], shifted[IN_W-2 -: PWM_W-1]};
    end else begin
      ext     = {8'b0, pend};
      shifted = ext << bus.gain;
      if (|shifted[XW-1:IN_W])
        duty_new = '1;
      else
        duty_new = shifted[IN_W-1 -: PWM_W];
    end
  end

  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      cnt           <= '0;
      acc           <= '0;
      duty_act      <= '0;
      pend          <= '0;
      pend_full     <= 1'b0;
      mode_act      <= MODE_PWM;
      pwm_out_q     <= 1'b0;
      period_tick_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      cnt           <= bus.enable ? cnt + 1'b1 : '0;
      period_tick_q <= boundary;

      // A boundary always drains the old pend; a same-cycle tick refills it without overrun.
      if (bus.sample_tick) begin
        pend      <= bus.sample_in;
        pend_full <= 1'b1;
        overrun_q <= pend_full && !boundary;
      end else begin
        overrun_q <= 1'b0;
        if (boundary)
          pend_full <= 1'b0;
      end

      if (boundary) begin
        mode_act <= mode_e'(bus.mode);
        if (pend_full)
          duty_act <= duty_new;
      end

      if (!bus.enable) begin
        acc       <= '0;
        pwm_out_q <= 1'b0;
      end else if (mode_act == MODE_SD) begin
        acc       <= (boundary && (mode_e'(bus.mode) != mode_act)) ? '0 : sd_sum[PWM_W-1:0];
        pwm_out_q <= sd_sum[PWM_W];
      end else begin
        acc       <= (boundary && (mode_e'(bus.mode) != mode_act)) ? '0 : acc;
        pwm_out_q <= (cnt < duty_act);
      end
    end
  end

  assign bus.pwm_out     = pwm_out_q;
  assign bus.period_tick = period_tick_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_pwm_audio_dac.sv
// Scoreboard bench for pwm_audio_dac (IN_W=16, PWM_W=10, SIGNED_IN=1).
module tb_pwm_audio_dac;

  localparam int IN_W  = 16;
  localparam int PWM_W = 10;
  localparam int PER   = 1 << PWM_W;

  logic clk  = 1'b0;
  logic RSTb = 1'b0;

  pwm_audio_dac_if #(.IN_W(IN_W)) bus ();

  pwm_audio_dac #(
    .IN_W      (IN_W),
    .PWM_W     (PWM_W),
    .SIGNED_IN (1'b1)
  ) dut (
    .clk  (clk),
    .RSTb (RSTb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input int got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sample(input logic [IN_W-1:0] v, output int ov);
    bus.sample_in   = v;
    bus.sample_tick = 1'b1;
    tick();
    ov = int'(bus.overrun);
    bus.sample_tick = 1'b0;
  endtask

  task automatic wait_ptick(output int waited);
    int found;
    found  = 0;
    waited = 0;
    while (!found && waited < 2 * PER + 50) begin
      tick();
      waited++;
      if (bus.period_tick) found = 1;
    end
    check_val("ptick_seen", found, 1);
  endtask

  // Counts ones over one full period; 'bad' counts ones off the every-4th-cycle grid.
  task automatic count_high(output int n, output int bad);
    n   = 0;
    bad = 0;
    for (int i = 0; i < PER; i++) begin
      tick();
      if (bus.pwm_out) begin
        n++;
        if ((i % 4) != 3) bad++;
      end
    end
  endtask

  logic [15:0] t_smp [6] = '{16'h0000, 16'h7FFF, 16'h8000, 16'h1000, 16'h2000, 16'hE000};
  int          t_gain[6] = '{0, 0, 0, 1, 2, 3};
  int          t_exp [6] = '{512, 1023, 0, 640, 1023, 0};

  initial begin
    int n, bad, ov, w, first, toggles;

    bus.sample_in   = '0;
    bus.sample_tick = 1'b0;
    bus.gain        = 3'd0;
    bus.mode        = 1'b0;
    bus.enable      = 1'b1;

    repeat (3) tick();
    check_val("rst_pwm_out", int'(bus.pwm_out), 0);
    check_val("rst_period_tick", int'(bus.period_tick), 0);
    check_val("rst_overrun", int'(bus.overrun), 0);

    RSTb = 1'b1;
    sb_push("first_ptick_cycle", PER - 1);
    sb_push("reset_toggles", 0);
    first   = -1;
    toggles = 0;
    for (int k = 0; k < 2 * PER; k++) begin
      tick();
      if (bus.pwm_out) toggles++;
      if (bus.period_tick) begin
        first = k;
        break;
      end
    end
    sb_pop_check(first);
    sb_pop_check(toggles);

    for (int t = 0; t < 6; t++) begin
      bus.gain = t_gain[t][2:0];
      drive_sample(t_smp[t], ov);
      sb_push($sformatf("duty_%h_g%0d", t_smp[t], t_gain[t]), t_exp[t]);
      wait_ptick(w);
      count_high(n, bad);
      sb_pop_check(n);
    end

    bus.gain = 3'd0;
    drive_sample(16'h0000, ov);
    check_val("ovr_first_tick", ov, 0);
    repeat (10) tick();
    drive_sample(16'h4000, ov);
    check_val("ovr_second_tick", ov, 1);
    tick();
    check_val("ovr_pulse_width", int'(bus.overrun), 0);
    sb_push("duty_after_ovr", 768);
    wait_ptick(w);
    count_high(n, bad);
    sb_pop_check(n);

    drive_sample(16'h7FFF, ov);
    repeat (PER - 2) tick();
    drive_sample(16'h8000, ov);
    check_val("coinc_align", int'(bus.period_tick), 1);
    check_val("coinc_no_ovr", ov, 0);
    sb_push("coinc_old_consumed", 1023);
    sb_push("coinc_new_next", 0);
    count_high(n, bad);
    sb_pop_check(n);
    count_high(n, bad);
    sb_pop_check(n);

    bus.mode = 1'b1;
    drive_sample(16'hC000, ov);
    sb_push("sd_ones", 256);
    sb_push("sd_spacing_errs", 0);
    wait_ptick(w);
    count_high(n, bad);
    sb_pop_check(n);
    sb_pop_check(bad);

    bus.mode = 1'b0;
    repeat (100) tick();
    drive_sample(16'h7FFF, ov);
    repeat (200) tick();
    bus.enable = 1'b0;
    tick();
    check_val("dis_pwm_out", int'(bus.pwm_out), 0);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (bus.pwm_out || bus.period_tick) bad++;
    end
    check_val("dis_quiet", bad, 0);
    drive_sample(16'h7FFF, ov);
    check_val("dis_overrun", ov, 1);
    bus.enable = 1'b1;
    sb_push("reen_ptick_delay", PER);
    sb_push("reen_duty", 1023);
    wait_ptick(w);
    sb_pop_check(w);
    count_high(n, bad);
    sb_pop_check(n);

    repeat (5) tick();
    check_val("pre_rst_pwm_out", int'(bus.pwm_out), 1);
    #3;
    RSTb = 1'b0;
    #1;
    check_val("async_rst_pwm_out", int'(bus.pwm_out), 0);
    check_val("async_rst_overrun", int'(bus.overrun), 0);
    @(posedge clk);
    #1;
    RSTb = 1'b1;

    check_val("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
